// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-less shifter: SLL / SRL / SRA by repeated small steps.
// Latency: shamt+1 edges from the accepting edge (1 for shamt=0); fast build floor(shamt/4)+(shamt%4)+1.
// Backpressure: none queued; start is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request, sampled only while IDLE
//   A      - shift amount source, only A[SW-1:0] is used
//   B      - operand to shift
//   ctrl   - 00 SLL, 01 SRL, 1x SRA
//   busy   - high whenever the sequencer is not IDLE
//   done   - registered one-cycle completion strobe
//   dout   - registered result, held between completions
//
// Build option: define SHIFT_SEQ_FAST_EN to take 4-bit steps while the
// remaining count is at least 4 (results are identical, only latency drops).
//
// WIDTH must be a power of two >= 4.

module shift_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_dout;
  logic             r_done;

  // ---------------------------------------------------------------------------
  // Next-state / datapath wires
  // ---------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_work_nxt;
  logic [SW-1:0]    w_cnt_nxt;
  logic [1:0]       w_op_nxt;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_done_nxt;

  logic             w_big_step;
  logic [SW-1:0]    w_step_amt;
  logic [WIDTH-1:0] w_work_step;
  logic [SW-1:0]    w_cnt_step;
  logic [SW-1:0]    w_shamt;

  // Upper bits of A never influence the operation.
  logic             w_unused_a;
  assign w_unused_a = ^A[WIDTH-1:SW];

  assign w_shamt = A[SW-1:0];

  // ---------------------------------------------------------------------------
  // Step size selection
  // ---------------------------------------------------------------------------
`ifdef SHIFT_SEQ_FAST_EN
  // Compare one bit wider so the constant 4 is representable even when SW=2
  // (WIDTH=4); in that case the count never reaches 4 and the big step is
  // never taken.
  assign w_big_step = ({1'b0, r_cnt} >= (SW+1)'(4));
`else
  assign w_big_step = 1'b0;
`endif

  assign w_step_amt = w_big_step ? SW'(4) : SW'(1);

  // One shift step of the working value in the latched op.
  function automatic logic [WIDTH-1:0] f_shift_step(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       op,
    input logic             big
  );
    logic [WIDTH-1:0] res;
    res = v;
    case (op)
      OP_SLL:  res = big ? (v << 4) : (v << 1);
      OP_SRL:  res = big ? (v >> 4) : (v >> 1);
      default: res = big ? WIDTH'($signed(v) >>> 4) : WIDTH'($signed(v) >>> 1);
    endcase
    return res;
  endfunction

  assign w_work_step = f_shift_step(r_work, r_op, w_big_step);
  // The count only decrements by a step no larger than itself, so it lands
  // exactly on zero and never wraps.
  assign w_cnt_step  = r_cnt - w_step_amt;

  // ---------------------------------------------------------------------------
  // FSM: next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_work_nxt = B;
          w_cnt_nxt  = w_shamt;
          w_op_nxt   = ctrl;
          if (w_shamt == '0) begin
            // Nothing to shift: complete on the accepting edge.
            w_state_nxt = ST_DONE;
            w_dout_nxt  = B;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        w_work_nxt = w_work_step;
        w_cnt_nxt  = w_cnt_step;
        if (w_cnt_step == '0) begin
          // Publish the final value on the same edge as entering DONE.
          w_state_nxt = ST_DONE;
          w_dout_nxt  = w_work_step;
          w_done_nxt  = 1'b1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign dout = r_dout;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  ctrl;
  logic        busy;
  logic        done;
  logic [31:0] dout;

`ifdef SHIFT_SEQ_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  shift_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .ctrl  (ctrl),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an accepted op finishes lat-1 edges after the accepting
  // edge; the sequencer takes new work again two edges after that.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [31:0] b, input int n, input logic [1:0] op);
    case (op)
      2'b00:   return b << n;
      2'b01:   return b >> n;
      default: return $signed(b) >>> n;
    endcase
  endfunction

  function automatic int ref_lat(input int n);
    if (FAST) return n / 4 + n % 4 + 1;
    return n + 1;
  endfunction

  int          ec   = 0;     // edge counter
  int          m_d  = -100;  // edge on which the current op completes
  logic [31:0] m_res  = '0;
  logic [31:0] m_dout = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d    = -100;
      m_dout = '0;
    end else begin
      ec++;
      if (start && ec >= m_d + 2) begin
        m_res = ref_result(B, int'(A[4:0]), ctrl);
        m_d   = ec + ref_lat(int'(A[4:0])) - 1;
      end
      if (ec == m_d) m_dout = m_res;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", {31'b0, busy}, {31'b0, (ec <= m_d)});
      check("done", {31'b0, done}, {31'b0, (ec == m_d)});
      check("dout", dout, m_dout);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed operation: waits one idle cycle, pulses start, then scrambles the
  // inputs so only latched values may matter. Counts edges from acceptance.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp_dout, input int exp_lat);
    int  k;
    bit  seen;
    @(negedge clk);
    A = a; B = b; ctrl = op; start = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 80) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        A = $urandom; B = $urandom; ctrl = 2'($urandom);
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s timeout: no done within 80 cycles, required within %0d", name, exp_lat);
    end else begin
      check({name, " latency"}, 32'(k), 32'(exp_lat));
      check({name, " dout"}, dout, exp_dout);
    end
  endtask

  initial begin
    int ndone;
    rst = 1'b0; start = 1'b0; A = '0; B = '0; ctrl = '0;

    // Reset asserted mid-clock, checked before any edge.
    #3 rst = 1'b1;
    #1;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset dout", dout, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Hand-computed vectors, issued back to back.
    run_op("sll1x5",   32'h0000_0005, 32'h0000_0001, 2'b00, 32'h0000_0020, FAST ? 3 : 6);
    run_op("sra31",    32'h0000_001F, 32'h8000_0000, 2'b10, 32'hFFFF_FFFF, FAST ? 11 : 32);
    run_op("srl31",    32'h0000_001F, 32'h8000_0000, 2'b01, 32'h0000_0001, FAST ? 11 : 32);
    run_op("zero",     32'h0000_0020, 32'hDEAD_BEEF, 2'b11, 32'hDEAD_BEEF, 1);
    run_op("sra_pos",  32'h0000_0003, 32'h4000_0000, 2'b11, 32'h0800_0000, 4);
    run_op("sll8",     32'hFFFF_FF08, 32'h0000_00FF, 2'b00, 32'h0000_FF00, FAST ? 3 : 9);
    run_op("sra4",     32'h0000_0004, 32'h8000_F000, 2'b10, 32'hF800_0F00, FAST ? 2 : 5);
    run_op("srl_one",  32'h0000_0001, 32'hA5A5_A5A5, 2'b01, 32'h52D2_D2D2, 2);

    // Collision: a second start during the operation must be dropped.
    @(negedge clk);
    A = 32'd4; B = 32'hF000_0000; ctrl = 2'b01; start = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 2) begin start = 1'b1; A = 32'd1; B = 32'h1; ctrl = 2'b00; end
      if (i == 3) start = 1'b0;
      if (done) ndone++;
    end
    check("collision done count", 32'(ndone), 32'd1);
    check("collision dout", dout, 32'h0F00_0000);

    // Abort: reset in the middle of a long shift.
    @(negedge clk);
    A = 32'd20; B = 32'h0000_FFFF; ctrl = 2'b00; start = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) ndone++;
    end
    #2 rst = 1'b1;
    #1;
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort done", {31'b0, done}, 32'h0);
    check("abort dout", dout, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    run_op("after_abort", 32'd1, 32'h0000_0003, 2'b00, 32'h0000_0006, 2);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
    $fatal(1);
  end

endmodule
